// File: rtl/ramb16_bwer_model_pkg.sv
// Shared constants, write-mode encoding and width helpers for the
// ramb16_bwer_model block RAM.
package ramb16_pkg;

  localparam int ARRAY_DEPTH = 512;
  localparam int WORD_BITS   = 32;
  localparam int PAR_BITS    = 4;
  localparam int ADDRW       = 14;
  localparam int WORDW       = 9;
  localparam int LANES       = 4;

  typedef enum logic [1:0] {
    WM_WRITE_FIRST,
    WM_READ_FIRST,
    WM_NO_CHANGE
  } write_mode_e;

  // Lowest address bit that still selects within the 36-bit word for a
  // given port width; 0 flags a width the RAM cannot be configured to.
  function automatic int width_to_lsb(input int width);
    case (width)
      36:      return 5;
      18:      return 4;
      9:       return 3;
      default: return 0;
    endcase
  endfunction

endpackage

// File: rtl/ramb16_bwer_model_if.sv
// One RAM port: enables, address, write data and read data.
interface ramb16_bwer_model_if;
  import ramb16_pkg::*;

  logic                 en;
  logic [LANES-1:0]     we;
  logic                 regce;
  logic                 rst;
  logic [ADDRW-1:0]     addr;
  logic [WORD_BITS-1:0] din;
  logic [PAR_BITS-1:0]  dinp;
  logic [WORD_BITS-1:0] dout;
  logic [PAR_BITS-1:0]  doutp;

  modport master (output en, we, regce, rst, addr, din, dinp,
                  input  dout, doutp);
  modport slave  (input  en, we, regce, rst, addr, din, dinp,
                  output dout, doutp);

endinterface

// File: rtl/ramb16_bwer_model_bram_port.sv
// Per-port logic: address decode, byte-lane write masking for the 9/18/36
// bit views, the output latch with its write-mode behaviour, and the
// optional output pipeline register.
module bram_port
  import ramb16_pkg::*;
#(
  parameter int    DATA_WIDTH = 36,
  parameter string WRITE_MODE = "NO_CHANGE",
  parameter int    DO_REG     = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  ramb16_bwer_model_if.slave   p,
  input  logic [WORD_BITS-1:0] rd_data,
  input  logic [PAR_BITS-1:0]  rd_par,
  output logic [WORDW-1:0]     word_addr,
  output logic [LANES-1:0]     wr_be,
  output logic [WORD_BITS-1:0] wr_data,
  output logic [PAR_BITS-1:0]  wr_par
);

  localparam write_mode_e MODE =
    (WRITE_MODE == "WRITE_FIRST") ? WM_WRITE_FIRST :
    (WRITE_MODE == "READ_FIRST")  ? WM_READ_FIRST  : WM_NO_CHANGE;

  if (width_to_lsb(DATA_WIDTH) == 0) begin : g_bad_width
    $error("bram_port: DATA_WIDTH must be 9, 18 or 36");
  end

  if (WRITE_MODE != "WRITE_FIRST" && WRITE_MODE != "READ_FIRST" &&
      WRITE_MODE != "NO_CHANGE") begin : g_bad_mode
    $error("bram_port: unknown WRITE_MODE");
  end

  logic [1:0]           sel;
  logic [WORD_BITS-1:0] bit_mask;
  logic [WORD_BITS-1:0] merged_data;
  logic [PAR_BITS-1:0]  merged_par;
  logic [35:0]          rd_fmt;
  logic [35:0]          wf_fmt;
  logic                 writing;
  logic [35:0]          out_lat;
  logic [35:0]          out_sel;
  logic                 unused_bits;

  // Narrow the 36-bit word down to this port's view; unused bits are 0.
  function automatic logic [35:0] fmt(input logic [WORD_BITS-1:0] d,
                                      input logic [PAR_BITS-1:0]  pp,
                                      input logic [1:0]           s);
    logic [35:0] r;
    r = '0;
    if (DATA_WIDTH == 36) begin
      r = {pp, d};
    end else if (DATA_WIDTH == 18) begin
      r = s[1] ? {2'b00, pp[3:2], 16'h0000, d[31:16]}
               : {2'b00, pp[1:0], 16'h0000, d[15:0]};
    end else begin
      r[7:0] = d[8*s +: 8];
      r[32]  = pp[s];
    end
    return r;
  endfunction

  // Decode the address and place write data/enables on the right lanes.
  always_comb begin
    word_addr = p.addr[ADDRW-1:5];
    sel       = p.addr[4:3];
    wr_be     = '0;
    wr_data   = '0;
    wr_par    = '0;
    if (DATA_WIDTH == 36) begin
      wr_be   = p.we;
      wr_data = p.din;
      wr_par  = p.dinp;
    end else if (DATA_WIDTH == 18) begin
      wr_be   = p.addr[4] ? {p.we[1:0], 2'b00} : {2'b00, p.we[1:0]};
      wr_data = {2{p.din[15:0]}};
      wr_par  = {2{p.dinp[1:0]}};
    end else begin
      wr_be   = p.we[0] ? (4'b0001 << sel) : 4'b0000;
      wr_data = {4{p.din[7:0]}};
      wr_par  = {4{p.dinp[0]}};
    end
    if (!p.en) begin
      wr_be = '0;
    end
    writing = (wr_be != '0);
  end

  // Build the stored word and the write-first word as the port would see them.
  always_comb begin
    bit_mask    = {{8{wr_be[3]}}, {8{wr_be[2]}}, {8{wr_be[1]}}, {8{wr_be[0]}}};
    merged_data = (rd_data & ~bit_mask) | (wr_data & bit_mask);
    merged_par  = (rd_par & ~wr_be) | (wr_par & wr_be);
    rd_fmt      = fmt(rd_data, rd_par, sel);
    wf_fmt      = fmt(merged_data, merged_par, sel);
  end

  // Output latch: sync reset beats read update, write mode picks the value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_lat <= '0;
    end else if (p.en) begin
      if (p.rst) begin
        out_lat <= '0;
      end else if (writing) begin
        if (MODE == WM_WRITE_FIRST) begin
          out_lat <= wf_fmt;
        end else if (MODE == WM_READ_FIRST) begin
          out_lat <= rd_fmt;
        end
      end else begin
        out_lat <= rd_fmt;
      end
    end
  end

  if (DO_REG != 0) begin : g_reg
    logic [35:0] out_reg;

    // Second output stage, advancing only when regce is high.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        out_reg <= '0;
      end else if (p.rst) begin
        out_reg <= '0;
      end else if (p.regce) begin
        out_reg <= out_lat;
      end
    end

    assign out_sel = out_reg;
  end else begin : g_noreg
    assign out_sel = out_lat;
  end

  assign p.dout      = out_sel[31:0];
  assign p.doutp     = out_sel[35:32];
  assign unused_bits = ^{p.regce, p.addr[2:0], p.din, p.dinp, p.we};

endmodule

// File: rtl/ramb16_bwer_model.sv
// 18Kb true-dual-port block RAM model (512 x 32 data + 4 parity) with byte
// write enables. Both ports share one clock and one array; port B wins a
// same-byte write-write collision and a cross-port read sees the old word.
// Optional build macro BRAM_COLLISION_X_EN: colliding bytes store X, a
// warning is printed, and cross-port reads of a word being written give X.
module ramb16_bwer_model
  import ramb16_pkg::*;
#(
  parameter int    DATA_WIDTH_A = 36,
  parameter int    DATA_WIDTH_B = 36,
  parameter string WRITE_MODE_A = "NO_CHANGE",
  parameter string WRITE_MODE_B = "NO_CHANGE",
  parameter int    DOA_REG      = 0,
  parameter int    DOB_REG      = 0
) (
  input logic                clk,
  input logic                rst_n,
  ramb16_bwer_model_if.slave port_a,
  ramb16_bwer_model_if.slave port_b
);

  logic [WORD_BITS-1:0] mem_data [ARRAY_DEPTH];
  logic [PAR_BITS-1:0]  mem_par  [ARRAY_DEPTH];

  logic [WORDW-1:0]     a_word, b_word;
  logic [LANES-1:0]     a_be, b_be;
  logic [WORD_BITS-1:0] a_wdata, b_wdata;
  logic [PAR_BITS-1:0]  a_wpar, b_wpar;
  logic [WORD_BITS-1:0] a_rdata, b_rdata;
  logic [PAR_BITS-1:0]  a_rpar, b_rpar;
  logic                 same_word;

  assign same_word = (a_word == b_word);

  // Asynchronous array read; each port registers it in its own latch.
  always_comb begin
    a_rdata = mem_data[a_word];
    a_rpar  = mem_par[a_word];
    b_rdata = mem_data[b_word];
    b_rpar  = mem_par[b_word];
`ifdef BRAM_COLLISION_X_EN
    if (same_word && b_be != '0) begin
      a_rdata = 'x;
      a_rpar  = 'x;
    end
    if (same_word && a_be != '0) begin
      b_rdata = 'x;
      b_rpar  = 'x;
    end
`endif
  end

  // Byte-lane array update; port A yields any lane port B also writes.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < LANES; i++) begin
        if (a_be[i] && !(b_be[i] && same_word)) begin
          mem_data[a_word][8*i +: 8] <= a_wdata[8*i +: 8];
          mem_par[a_word][i]         <= a_wpar[i];
        end
        if (b_be[i]) begin
`ifdef BRAM_COLLISION_X_EN
          if (a_be[i] && same_word) begin
            mem_data[b_word][8*i +: 8] <= 8'hxx;
            mem_par[b_word][i]         <= 1'bx;
          end else begin
            mem_data[b_word][8*i +: 8] <= b_wdata[8*i +: 8];
            mem_par[b_word][i]         <= b_wpar[i];
          end
`else
          mem_data[b_word][8*i +: 8] <= b_wdata[8*i +: 8];
          mem_par[b_word][i]         <= b_wpar[i];
`endif
        end
      end
    end
  end

`ifdef BRAM_COLLISION_X_EN
  // Report write-write collisions on the same byte lane.
  always_ff @(posedge clk) begin
    if (rst_n && same_word && (a_be & b_be) != '0) begin
      $display("ramb16_bwer_model: write collision at time %0t word 0x%03h lanes %b",
               $time, a_word, a_be & b_be);
    end
  end
`endif

  bram_port #(
    .DATA_WIDTH (DATA_WIDTH_A),
    .WRITE_MODE (WRITE_MODE_A),
    .DO_REG     (DOA_REG)
  ) u_port_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .p         (port_a),
    .rd_data   (a_rdata),
    .rd_par    (a_rpar),
    .word_addr (a_word),
    .wr_be     (a_be),
    .wr_data   (a_wdata),
    .wr_par    (a_wpar)
  );

  bram_port #(
    .DATA_WIDTH (DATA_WIDTH_B),
    .WRITE_MODE (WRITE_MODE_B),
    .DO_REG     (DOB_REG)
  ) u_port_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .p         (port_b),
    .rd_data   (b_rdata),
    .rd_par    (b_rpar),
    .word_addr (b_word),
    .wr_be     (b_be),
    .wr_data   (b_wdata),
    .wr_par    (b_wpar)
  );

endmodule

// File: tb/tb_ramb16_bwer_model.sv
// Scoreboard bench for ramb16_bwer_model. Five instances share one stimulus
// stream: d0 NO_CHANGE, d1 WRITE_FIRST, d2 READ_FIRST, d3 DOA_REG=1,
// d4 port A 18-bit / port B 9-bit.
module tb_ramb16_bwer_model;

  typedef struct packed {
    logic        en;
    logic [3:0]  we;
    logic [13:0] addr;
    logic [31:0] din;
    logic [3:0]  dip;
    logic        rst;
    logic        regce;
  } op_t;

  typedef struct {
    string       tag;
    int          dut;
    bit          on_b;
    int          due;
    logic [35:0] value;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  op_t         cur_a, cur_b;
  logic [35:0] out_a [5];
  logic [35:0] out_b [5];
  int          cyc = 0;
  int          tests = 0;
  int          failed = 0;
  exp_t        sb [$];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 5; g++) begin : g_dut
    ramb16_bwer_model_if pa ();
    ramb16_bwer_model_if pb ();

    assign pa.en    = cur_a.en;
    assign pa.we    = cur_a.we;
    assign pa.addr  = cur_a.addr;
    assign pa.din   = cur_a.din;
    assign pa.dinp  = cur_a.dip;
    assign pa.rst   = cur_a.rst;
    assign pa.regce = cur_a.regce;
    assign pb.en    = cur_b.en;
    assign pb.we    = cur_b.we;
    assign pb.addr  = cur_b.addr;
    assign pb.din   = cur_b.din;
    assign pb.dinp  = cur_b.dip;
    assign pb.rst   = cur_b.rst;
    assign pb.regce = cur_b.regce;

    ramb16_bwer_model #(
      .DATA_WIDTH_A ((g == 4) ? 18 : 36),
      .DATA_WIDTH_B ((g == 4) ? 9 : 36),
      .WRITE_MODE_A ((g == 1) ? "WRITE_FIRST" : (g == 2) ? "READ_FIRST" : "NO_CHANGE"),
      .WRITE_MODE_B ("NO_CHANGE"),
      .DOA_REG      ((g == 3) ? 1 : 0),
      .DOB_REG      (0)
    ) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .port_a (pa),
      .port_b (pb)
    );

    assign out_a[g] = {pa.doutp, pa.dout};
    assign out_b[g] = {pb.doutp, pb.dout};
  end

  function automatic op_t op_idle();
    op_t o;
    o = '0;
    o.regce = 1'b1;
    return o;
  endfunction

  function automatic op_t op_read(input logic [13:0] addr);
    op_t o;
    o = op_idle();
    o.en = 1'b1;
    o.addr = addr;
    return o;
  endfunction

  function automatic op_t op_write(input logic [13:0] addr, input logic [3:0] we,
                                   input logic [31:0] din, input logic [3:0] dip);
    op_t o;
    o = op_read(addr);
    o.we = we;
    o.din = din;
    o.dip = dip;
    return o;
  endfunction

  task automatic checkOutput(input string tag, input logic [35:0] got, input logic [35:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input op_t a, input op_t b);
    @(posedge clk);
    #2;
    cur_a = a;
    cur_b = b;
  endtask

  task automatic expectOut(input string tag, input int dut, input bit on_b,
                           input int lat, input logic [35:0] value);
    exp_t e;
    e.tag = tag;
    e.dut = dut;
    e.on_b = on_b;
    e.due = cyc + lat;
    e.value = value;
    sb.push_back(e);
  endtask

  // Compare every scoreboard entry whose output cycle has arrived.
  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].due == cyc) begin
        checkOutput($sformatf("%s/d%0d%s", sb[i].tag, sb[i].dut, sb[i].on_b ? "B" : "A"),
                    sb[i].on_b ? out_b[sb[i].dut] : out_a[sb[i].dut], sb[i].value);
        sb.delete(i);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    op_t o;
    rst_n = 1'b0;
    cur_a = op_idle();
    cur_b = op_idle();
    repeat (3) @(posedge clk);
    #2;
    for (int i = 0; i < 5; i++) begin
      checkOutput($sformatf("reset_a/d%0d", i), out_a[i], 36'h0);
      checkOutput($sformatf("reset_b/d%0d", i), out_b[i], 36'h0);
    end
    rst_n = 1'b1;

    applyStimulus(op_write(14'h0020, 4'hF, 32'h5A5A5A5A, 4'hA),
                  op_write(14'h0040, 4'hF, 32'h00000000, 4'h0));
    expectOut("wf_full", 1, 0, 1, {4'hA, 32'h5A5A5A5A});
    expectOut("rf_full", 2, 0, 1, 36'h0);
    expectOut("nc_full", 0, 0, 1, 36'h0);

    applyStimulus(op_write(14'h0040, 4'b0101, 32'hAABBCCDD, 4'hF), op_idle());
    expectOut("wf_bytes", 1, 0, 1, {4'b0101, 32'h00BB00DD});
    expectOut("rf_bytes", 2, 0, 1, 36'h0);
    expectOut("nc_bytes", 0, 0, 1, 36'h0);

    applyStimulus(op_read(14'h0040), op_idle());
    for (int i = 0; i < 3; i++) expectOut("rd_bytes", i, 0, 1, {4'b0101, 32'h00BB00DD});
    expectOut("rd_bytes_reg", 3, 0, 2, {4'b0101, 32'h00BB00DD});

    applyStimulus(op_idle(), op_write(14'h0040, 4'hF, 32'h12345678, 4'h0));
    expectOut("nc_b_hold", 0, 1, 1, 36'h0);

    applyStimulus(op_read(14'h0040), op_read(14'h0020));
    for (int i = 0; i < 3; i++) expectOut("rd_line", i, 0, 1, {4'h0, 32'h12345678});
    expectOut("rd_line_reg", 3, 0, 2, {4'h0, 32'h12345678});
    expectOut("rd_b", 0, 1, 1, {4'hA, 32'h5A5A5A5A});

    applyStimulus(op_idle(), op_write(14'h0080, 4'hF, 32'h11111111, 4'h0));
    applyStimulus(op_write(14'h0080, 4'hF, 32'hDEADBEEF, 4'h0), op_idle());
    expectOut("mode_nc", 0, 0, 1, {4'h0, 32'h12345678});
    expectOut("mode_wf", 1, 0, 1, {4'h0, 32'hDEADBEEF});
    expectOut("mode_rf", 2, 0, 1, {4'h0, 32'h11111111});

    applyStimulus(op_write(14'h00C0, 4'hF, 32'h33333333, 4'h3),
                  op_write(14'h00A0, 4'hF, 32'hCAFEF00D, 4'h0));
    applyStimulus(op_read(14'h00A0), op_idle());
    expectOut("reg_stage1", 3, 0, 1, {4'h0, 32'h12345678});
    expectOut("reg_stage2", 3, 0, 2, {4'h0, 32'hCAFEF00D});
    expectOut("rd_cafe", 0, 0, 1, {4'h0, 32'hCAFEF00D});
    applyStimulus(op_idle(), op_idle());

    o = op_read(14'h0040);
    o.regce = 1'b0;
    applyStimulus(o, op_idle());
    o = op_idle();
    o.regce = 1'b0;
    applyStimulus(o, op_idle());
    expectOut("regce_hold", 3, 0, 1, {4'h0, 32'hCAFEF00D});
    applyStimulus(op_idle(), op_idle());
    expectOut("regce_load", 3, 0, 1, {4'h0, 32'h12345678});

    applyStimulus(op_write(14'h0060, 4'hF, 32'h00000001, 4'h1),
                  op_write(14'h0060, 4'hF, 32'h00000002, 4'h2));
    applyStimulus(op_read(14'h0060), op_idle());
`ifndef BRAM_COLLISION_X_EN
    expectOut("collide_b_wins", 0, 0, 1, {4'h2, 32'h00000002});
`endif

    applyStimulus(op_write(14'h00C0, 4'hF, 32'h77777777, 4'h0), op_read(14'h00C0));
    expectOut("xport_old", 0, 1, 1, {4'h3, 32'h33333333});

    o = op_read(14'h0040);
    o.rst = 1'b1;
    applyStimulus(o, op_read(14'h00C0));
    expectOut("sync_rst", 0, 0, 1, 36'h0);
    expectOut("sync_rst", 1, 0, 1, 36'h0);
    expectOut("xport_new", 0, 1, 1, {4'h0, 32'h77777777});

    applyStimulus(op_read(14'h0020), op_idle());
    expectOut("rd_after_rst", 1, 0, 1, {4'hA, 32'h5A5A5A5A});
    o = op_write(14'h00E0, 4'hF, 32'h0F0F0F0F, 4'hF);
    o.rst = 1'b1;
    applyStimulus(o, op_idle());
    expectOut("rst_over_wf", 1, 0, 1, 36'h0);
    applyStimulus(op_idle(), op_read(14'h00E0));
    expectOut("rst_write_done", 0, 1, 1, {4'hF, 32'h0F0F0F0F});

    applyStimulus(op_read(14'h0020), op_idle());
    expectOut("rd_0020", 0, 0, 1, {4'hA, 32'h5A5A5A5A});
    o = op_write(14'h0040, 4'hF, 32'hFFFFFFFF, 4'hF);
    o.en = 1'b0;
    applyStimulus(o, op_idle());
    expectOut("en_low_hold", 0, 0, 1, {4'hA, 32'h5A5A5A5A});
    applyStimulus(op_read(14'h0040), op_idle());
    expectOut("en_low_nowrite", 0, 0, 1, {4'h0, 32'h12345678});
    applyStimulus(op_idle(), op_read(14'h0040));

    applyStimulus(op_write(14'h0020, 4'hF, 32'hFFFFFFFF, 4'hF), op_idle());
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 5; i++) begin
      checkOutput($sformatf("async_rst_a/d%0d", i), out_a[i], 36'h0);
      checkOutput($sformatf("async_rst_b/d%0d", i), out_b[i], 36'h0);
    end
    applyStimulus(op_idle(), op_idle());
    rst_n = 1'b1;
    applyStimulus(op_read(14'h0020), op_idle());
    expectOut("array_kept", 0, 0, 1, {4'hA, 32'h5A5A5A5A});
    expectOut("array_kept_reg", 3, 0, 2, {4'hA, 32'h5A5A5A5A});

    applyStimulus(op_write(14'h1010, 4'b0011, 32'h0000BEEF, 4'b0010), op_idle());
    applyStimulus(op_idle(), op_write(14'h1008, 4'b0001, 32'h000000A5, 4'b0001));
    applyStimulus(op_read(14'h1000), op_read(14'h1018));
    expectOut("w18_low_half", 4, 0, 1, {4'b0010, 32'h0000A500});
    expectOut("w9_lane3", 4, 1, 1, {4'b0001, 32'h000000BE});
    applyStimulus(op_read(14'h1010), op_idle());
    expectOut("w18_high_half", 4, 0, 1, {4'b0010, 32'h0000BEEF});

    applyStimulus(op_idle(), op_idle());
    repeat (3) @(posedge clk);
    #3;
    checkOutput("scoreboard_drained", 36'(sb.size()), 36'h0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
